// File: rtl/polar_enc_pkg.sv
// Shared types and the butterfly helper for the streaming polar encoder.
// Optional feature macro: POLAR_ENC_SYSTEMATIC_EN (adds the ZERO/ENC2 states).
package polar_enc_pkg;

  // Widest code length the butterfly helper supports; narrower vectors are
  // zero-extended into it and truncated back by the caller.
  localparam int unsigned PolarMaxN = 4096;

  // Encoder control states.
`ifdef POLAR_ENC_SYSTEMATIC_EN
  typedef enum logic [2:0] {
    StLoad,
    StEnc,
    StZero,
    StEnc2,
    StSend
  } polar_state_e;
`else
  typedef enum logic [2:0] {
    StLoad,
    StEnc,
    StSend
  } polar_state_e;
`endif

  // One butterfly stage of x = u * F^{(x)n} in natural order: every index i
  // with bit s clear absorbs its partner i + 2^s.
  function automatic logic [PolarMaxN-1:0] stage_xor(input logic [PolarMaxN-1:0] vec,
                                                     input int unsigned s);
    logic [PolarMaxN-1:0] res;
    int unsigned          span;
    span = 32'd1 << s;
    res  = vec;
    for (int unsigned i = 0; i < PolarMaxN; i++) begin
      if (((i & span) == 0) && ((i + span) < PolarMaxN)) begin
        res[i] = vec[i] ^ vec[i + span];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// Combinational single butterfly stage of the polar transform.
// The stage index selects the XOR distance 2^stage.
module polar_butterfly_stage #(
  parameter int unsigned N      = 1024,
  parameter int unsigned StageW = 4
) (
  input  logic [N-1:0]      din,
  input  logic [StageW-1:0] stage,
  output logic [N-1:0]      dout
);
  import polar_enc_pkg::*;

  // Widen to the helper's fixed width, apply the stage, narrow back.
  always_comb begin
    dout = N'(stage_xor(PolarMaxN'(din), 32'(stage)));
  end

endmodule

// File: rtl/polar_encoder.sv
// Streaming polar encoder: loads u in W-bit beats (frozen bits forced to 0),
// runs LOG2N butterfly stages one per cycle, then streams x out in W-bit beats.
// Optional feature macro: POLAR_ENC_SYSTEMATIC_EN -- systematic encoding
// (encode, re-zero frozen positions, encode again).
module polar_encoder #(
  parameter int unsigned N     = 1024,
  parameter int unsigned W     = 32,
  parameter int unsigned LOG2N = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] frozen_mask,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);
  import polar_enc_pkg::*;

  localparam int unsigned Beats  = N / W;
  localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned StageW = $clog2(LOG2N + 1);

  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(Beats - 1);
  localparam logic [StageW-1:0] LastStage = StageW'(LOG2N - 1);

  polar_state_e      state_q, state_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [StageW-1:0] stage_q, stage_d;
  logic [N-1:0]      vec_q, vec_d;
  logic [N-1:0]      mask_q, mask_d;
  logic [N-1:0]      mask_sel;
  logic [N-1:0]      stage_out;

  polar_butterfly_stage #(
    .N      (N),
    .StageW (StageW)
  ) u_stage (
    .din   (vec_q),
    .stage (stage_q),
    .dout  (stage_out)
  );

  // Next-state logic: beat loading, butterfly stages and output draining.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    stage_d = stage_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    // Beat 0 uses the live mask since the latched copy is only written on that beat.
    mask_sel = (beat_q == '0) ? frozen_mask : mask_q;

    unique case (state_q)
      StLoad: begin
        if (in_valid && in_ready) begin
          vec_d[beat_q*W +: W] = in_data & ~mask_sel[beat_q*W +: W];
          if (beat_q == '0) begin
            mask_d = frozen_mask;
          end
          if (beat_q == LastBeat) begin
            state_d = StEnc;
            beat_d  = '0;
            stage_d = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      StEnc: begin
        vec_d = stage_out;
        if (stage_q == LastStage) begin
          stage_d = '0;
`ifdef POLAR_ENC_SYSTEMATIC_EN
          state_d = StZero;
`else
          state_d = StSend;
`endif
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end

`ifdef POLAR_ENC_SYSTEMATIC_EN
      StZero: begin
        vec_d   = vec_q & ~mask_q;
        state_d = StEnc2;
      end

      StEnc2: begin
        vec_d = stage_out;
        if (stage_q == LastStage) begin
          stage_d = '0;
          state_d = StSend;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
`endif

      StSend: begin
        if (out_valid && out_ready) begin
          if (beat_q == LastBeat) begin
            state_d = StLoad;
            beat_d  = '0;
            stage_d = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StLoad;
        beat_d  = '0;
        stage_d = '0;
      end
    endcase
  end

  // State registers plus outputs registered from the next state, so they
  // track the state the encoder is about to be in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      beat_q    <= '0;
      stage_q   <= '0;
      vec_q     <= '0;
      mask_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      stage_q   <= stage_d;
      vec_q     <= vec_d;
      mask_q    <= mask_d;
      in_ready  <= (state_d == StLoad);
      out_valid <= (state_d == StSend);
      out_data  <= (state_d == StSend) ? vec_d[beat_d*W +: W] : '0;
      out_last  <= (state_d == StSend) && (beat_d == LastBeat);
      busy      <= !((state_d == StLoad) && (beat_d == '0));
    end
  end

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder at N=8, W=4 with a scoreboard of
// expected output beats. Honors POLAR_ENC_SYSTEMATIC_EN for its expectations.
module tb_polar_encoder;

  localparam int unsigned N     = 8;
  localparam int unsigned W     = 4;
  localparam int unsigned LOG2N = 3;
  localparam int unsigned Beats = N / W;
`ifdef POLAR_ENC_SYSTEMATIC_EN
  localparam bit          Sys    = 1'b1;
  localparam int unsigned ExpLat = 2 * LOG2N + 1;
`else
  localparam bit          Sys    = 1'b0;
  localparam int unsigned ExpLat = LOG2N;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] frozen_mask;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {last, data}.
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  polar_encoder #(
    .N     (N),
    .W     (W),
    .LOG2N (LOG2N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frozen_mask (frozen_mask),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  // Generator-matrix view: x[j] is the XOR of u[i] over all i whose bits cover j.
  function automatic logic [N-1:0] transform(input logic [N-1:0] u);
    logic [N-1:0] x;
    x = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if ((i & j) == j) x[j] = x[j] ^ u[i];
      end
    end
    return x;
  endfunction

  function automatic logic [N-1:0] model(input logic [N-1:0] mask, input logic [N-1:0] u);
    logic [N-1:0] x;
    x = transform(u & ~mask);
    if (Sys) x = transform(x & ~mask);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; mask_late is presented after beat 0 to prove the mask is latched.
  task automatic send_frame(input logic [N-1:0] mask, input logic [N-1:0] u, input int gap,
                            input logic [N-1:0] mask_late);
    logic [N-1:0] x;
    int           n;
    x = model(mask, u);
    for (int k = 0; k < Beats; k++) begin
      sb.push_back({(k == Beats - 1), x[k*W +: W]});
    end
    frozen_mask = mask;
    for (int k = 0; k < Beats; k++) begin
      if (k > 0) begin
        frozen_mask = mask_late;
        if (gap > 0) begin
          in_valid = 1'b0;
          repeat (gap) tick();
          check("busy_in_gap", busy, 1);
          check("in_ready_in_gap", in_ready, 1);
        end
      end
      in_valid = 1'b1;
      in_data  = u[k*W +: W];
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      check("in_ready_load", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Drain one frame from the scoreboard, optionally stalling beat 0.
  task automatic recv_frame(input int stall);
    logic [W:0] exp;
    int         lat;
    int         n;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("latency", lat, ExpLat);
    for (int k = 0; k < Beats; k++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      check("out_valid", out_valid, 1);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      if (k == 0 && stall > 0) begin
        out_ready = 1'b0;
        repeat (stall) begin
          tick();
          check("stall_out_data", out_data, exp[W-1:0]);
          check("stall_out_valid", out_valid, 1);
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      check("out_data", out_data, exp[W-1:0]);
      check("out_last", out_last, exp[W]);
      tick();
    end
    check("done_out_valid", out_valid, 0);
    check("done_in_ready", in_ready, 1);
    check("done_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    frozen_mask = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    send_frame(8'h00, 8'h80, 0, 8'h00);
    recv_frame(0);
    send_frame(8'h00, 8'h02, 0, 8'h00);
    recv_frame(0);
    send_frame(8'h00, 8'h01, 0, 8'h00);
    recv_frame(0);
    // Input gap plus a changed mask on beat 1 that must be ignored.
    send_frame(8'h0F, 8'hFF, 2, 8'hFF);
    recv_frame(0);
    send_frame(8'h0F, 8'hA0, 0, 8'h0F);
    recv_frame(0);
    // Backpressure on the first output beat.
    send_frame(8'h00, 8'h80, 0, 8'h00);
    recv_frame(5);

    // Reset after one accepted beat discards the partial frame.
    frozen_mask = '0;
    in_valid    = 1'b1;
    in_data     = 4'hF;
    tick();
    in_valid = 1'b0;
    check("partial_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    send_frame(8'h00, 8'h80, 0, 8'h00);
    recv_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/polar_encoder.md
Name: polar_encoder

Overview:
- Streaming polar encoder, the transmit-side counterpart of the SCAN decoder PE array.
- Accepts a length-N source vector u in W-bit beats and forces frozen positions to 0.
- Computes x = u·F^{⊗n} (F = [[1,0],[1,1]], natural order, no bit reversal), one butterfly stage per cycle.
- Streams x out in W-bit beats; used both as the frame source and for re-encoding decoded hard decisions in the codec loopback.

Parameters:
- N, 1024, code length; power of two, ≥ 2.
- W, 32, beat width in bits; power of two; W divides N.
- LOG2N, $clog2(N), number of butterfly stages.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- frozen_mask  in  N  bit i = 1 means u[i] is frozen; sampled on the first accepted input beat of a frame
- in_valid  in  1  input beat valid
- in_ready  out  1  encoder can accept a beat
- in_data  in  W  u bits; beat k carries u[k*W+W-1 : k*W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  W  x bits; beat k carries x[k*W+W-1 : k*W]
- out_last  out  1  high on the final beat (k = N/W-1)
- busy  out  1  high in every state except LOAD with zero beats accepted

Behaviour:
- Reset values: state = LOAD; beat counter = 0; stage counter = 0; vector register = 0; in_ready = 1; out_valid = 0; out_data = 0; out_last = 0; busy = 0.
- A transfer occurs on a rising edge with valid && ready; data is held stable while valid && !ready.
- LOAD:
  - in_ready = 1.
  - Each transfer writes in_data & ~frozen_mask[slice] into vec[k*W +: W].
  - The mask is latched on beat 0.
  - After beat N/W-1: go to ENC, clear the stage counter.
- ENC:
  - in_ready = 0.
  - Stage s: for every i with bit s of i equal to 0, vec[i] <= vec[i] ^ vec[i + 2^s].
  - One stage per cycle, s = 0..LOG2N-1; after stage LOG2N-1 go to SEND.
- SEND:
  - out_valid = 1; out_data = vec[k*W +: W]; out_last = (k == N/W-1).
  - On the last transfer: go to LOAD, clear the counters. out_valid drops on the following cycle.
- Latency:
  - First output beat is valid LOG2N cycles after the cycle that accepted the last input beat.
  - With the optional feature: 2*LOG2N+1 cycles.
- Throughput: one frame per (N/W + LOG2N + N/W) cycles at full handshake. There is no input/output overlap: in_ready = 0 during SEND.
- Backpressure: out_ready low stalls SEND indefinitely with the state held; no beats are lost.
- Input gaps: in_valid low during LOAD simply pauses the beat counter.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values on the next edge.
- Counter widths: beat counter $clog2(N/W) bits, stage counter $clog2(LOG2N+1) bits; wraps are never relied on.

Optional Feature:
- POLAR_ENC_SYSTEMATIC_EN defined: systematic encoding.
  - After ENC: one ZERO cycle does vec <= vec & ~mask.
  - ENC2 then reruns all LOG2N stages before SEND.
  - Result: x[i] = u[i] for every unfrozen i.
- Undefined: the ZERO/ENC2 states do not exist; non-systematic x = u·F^{⊗n}.

Decomposition:
- Package polar_enc_pkg:
  - state enum (LOAD, ENC, ZERO, ENC2, SEND);
  - function stage_xor(vec, s) returning the stage-s butterfly result.
- One sub-module, polar_butterfly_stage: combinational, N-bit vector in, stage index in, N-bit vector out.
- The top module holds the FSM, counters, vector register and handshakes.

Test Plan (N=8, W=4 unless noted):
- mask=0x00, u=0x80 (u7=1) -> x=0xFF; out beats 0xF, 0xF; out_last on beat 1; first out_valid 3 cycles after last input.
- mask=0x00, u=0x02 -> x=0x03; u=0x01 -> x=0x01.
- mask=0x0F, u=0xFF -> effective u=0xF0 -> x=0x88.
- Systematic build, mask=0x0F, u=0xA0 -> x=0xAA; x[7:4]=0xA equals info bits; latency 7 cycles.
- out_ready held low 5 cycles during SEND beat 0 -> out_data stays 0xF (u=0x80 case); no beat lost or duplicated; in_ready stays 0.
- rst asserted after beat 0 accepted -> next cycle in_ready=1, out_valid=0, busy=0; a fresh frame u=0x80 then yields x=0xFF.
